// File: rtl/decode_queue.sv
// decode_queue: registered RV32I decode stage feeding execute through a
// small FIFO. Each accepted word is decoded on entry and only the decoded
// fields plus the PC tag are stored. Supports back-pressure, synchronous
// flush, an explicit illegal flag and an optional PMUL extension.
module decode_queue #(
  parameter int DEPTH       = 2,
  parameter bit ENABLE_PMUL = 1'b1,
  parameter int PC_WIDTH    = 32
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    flush_in,
  input  logic                    inst_valid_in,
  input  logic [31:0]             inst_in,
  input  logic [PC_WIDTH-1:0]     pc_in,
  output logic                    inst_ready_out,
  output logic                    dec_valid_out,
  input  logic                    dec_ready_in,
  output logic [3:0]              itype_out,
  output logic [3:0]              alu_func_out,
  output logic [2:0]              br_func_out,
  output logic [2:0]              mem_func_out,
  output logic [4:0]              dst_out,
  output logic [4:0]              src1_out,
  output logic [4:0]              src2_out,
  output logic [31:0]             imm_out,
  output logic [PC_WIDTH-1:0]     pc_out,
  output logic                    illegal_out,
  output logic [$clog2(DEPTH):0]  count_out
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [3:0] {
    IT_OP = 4'd0, IT_OPIMM = 4'd1, IT_BRANCH = 4'd2, IT_LUI = 4'd3,
    IT_JAL = 4'd4, IT_JALR = 4'd5, IT_LOAD = 4'd6, IT_STORE = 4'd7,
    IT_AUIPC = 4'd8, IT_PMUL = 4'd9, IT_UNSUP = 4'd10
  } itype_e;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3,
    ALU_XOR = 4'd4, ALU_SLT = 4'd5, ALU_SLTU = 4'd6, ALU_SLL = 4'd7,
    ALU_SRL = 4'd8, ALU_SRA = 4'd9
  } alu_e;

  typedef enum logic [2:0] {
    BR_EQ = 3'd0, BR_NE = 3'd1, BR_LT = 3'd2, BR_LTU = 3'd3,
    BR_GE = 3'd4, BR_GEU = 3'd5
  } br_e;

  typedef enum logic [2:0] {
    MEM_LW = 3'd0, MEM_LH = 3'd1, MEM_LHU = 3'd2, MEM_LB = 3'd3,
    MEM_LBU = 3'd4, MEM_SW = 3'd5, MEM_SH = 3'd6, MEM_SB = 3'd7
  } mem_e;

  typedef enum logic [2:0] {
    IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
  } imm_sel_e;

  typedef struct packed {
    logic [3:0]          itype;
    logic [3:0]          alu;
    logic [2:0]          br;
    logic [2:0]          mem;
    logic [4:0]          dst;
    logic [4:0]          src1;
    logic [4:0]          src2;
    logic [31:0]         imm;
    logic [PC_WIDTH-1:0] pc;
  } entry_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  // Instruction word fields
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] rd, rs1, rs2;

  assign opcode = inst_in[6:0];
  assign rd     = inst_in[11:7];
  assign funct3 = inst_in[14:12];
  assign rs1    = inst_in[19:15];
  assign rs2    = inst_in[24:20];
  assign funct7 = inst_in[31:25];

  // Sign bit is always inst[31]; B and J immediates have bit 0 cleared
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign imm_i = {{20{inst_in[31]}}, inst_in[31:20]};
  assign imm_s = {{20{inst_in[31]}}, inst_in[31:25], inst_in[11:7]};
  assign imm_b = {{19{inst_in[31]}}, inst_in[31], inst_in[7],
                  inst_in[30:25], inst_in[11:8], 1'b0};
  assign imm_u = {inst_in[31:12], 12'b0};
  assign imm_j = {{11{inst_in[31]}}, inst_in[31], inst_in[19:12],
                  inst_in[20], inst_in[30:21], 1'b0};

  itype_e   itype;
  alu_e     alu;
  br_e      br;
  mem_e     mem;
  imm_sel_e imm_sel;

  // Classify the incoming word; anything not recognised falls to Unsupported
  always_comb begin
    itype   = IT_UNSUP;
    alu     = ALU_ADD;
    br      = BR_EQ;
    mem     = MEM_LW;
    imm_sel = IMM_NONE;
    case (opcode)
      OPC_OP: begin
        if (funct7 == 7'b0000000) begin
          itype = IT_OP;
          case (funct3)
            3'b000:  alu = ALU_ADD;
            3'b001:  alu = ALU_SLL;
            3'b010:  alu = ALU_SLT;
            3'b011:  alu = ALU_SLTU;
            3'b100:  alu = ALU_XOR;
            3'b101:  alu = ALU_SRL;
            3'b110:  alu = ALU_OR;
            default: alu = ALU_AND;
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          itype = IT_OP;
          alu   = ALU_SUB;
        end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
          itype = IT_OP;
          alu   = ALU_SRA;
        end else if (ENABLE_PMUL && funct7 == 7'b0000001 && funct3 == 3'b001) begin
          itype = IT_PMUL;
        end
      end
      OPC_OPIMM: begin
        imm_sel = IMM_I;
        itype   = IT_OPIMM;
        case (funct3)
          3'b000: alu = ALU_ADD;
          3'b010: alu = ALU_SLT;
          3'b011: alu = ALU_SLTU;
          3'b100: alu = ALU_XOR;
          3'b110: alu = ALU_OR;
          3'b111: alu = ALU_AND;
          3'b001: begin
            alu = ALU_SLL;
            if (funct7 != 7'b0000000) itype = IT_UNSUP;
          end
          default: begin
            if (funct7 == 7'b0000000)      alu = ALU_SRL;
            else if (funct7 == 7'b0100000) alu = ALU_SRA;
            else                           itype = IT_UNSUP;
          end
        endcase
      end
      OPC_BRANCH: begin
        imm_sel = IMM_B;
        itype   = IT_BRANCH;
        case (funct3)
          3'b000:  br = BR_EQ;
          3'b001:  br = BR_NE;
          3'b100:  br = BR_LT;
          3'b101:  br = BR_GE;
          3'b110:  br = BR_LTU;
          3'b111:  br = BR_GEU;
          default: itype = IT_UNSUP;
        endcase
      end
      OPC_LUI: begin
        itype   = IT_LUI;
        imm_sel = IMM_U;
      end
      OPC_AUIPC: begin
        itype   = IT_AUIPC;
        imm_sel = IMM_U;
      end
      OPC_JAL: begin
        itype   = IT_JAL;
        imm_sel = IMM_J;
      end
      OPC_JALR: begin
        imm_sel = IMM_I;
        if (funct3 == 3'b000) itype = IT_JALR;
      end
      OPC_LOAD: begin
        imm_sel = IMM_I;
        itype   = IT_LOAD;
        case (funct3)
          3'b000:  mem = MEM_LB;
          3'b001:  mem = MEM_LH;
          3'b010:  mem = MEM_LW;
          3'b100:  mem = MEM_LBU;
          3'b101:  mem = MEM_LHU;
          default: itype = IT_UNSUP;
        endcase
      end
      OPC_STORE: begin
        imm_sel = IMM_S;
        itype   = IT_STORE;
        case (funct3)
          3'b000:  mem = MEM_SB;
          3'b001:  mem = MEM_SH;
          3'b010:  mem = MEM_SW;
          default: itype = IT_UNSUP;
        endcase
      end
      default: itype = IT_UNSUP;
    endcase
  end

  entry_t dec_entry;

  // Build the stored entry, zeroing fields the instruction type does not use
  always_comb begin
    dec_entry       = '0;
    dec_entry.itype = itype;
    dec_entry.pc    = pc_in;
    if (itype != IT_UNSUP) begin
      dec_entry.alu = (itype == IT_OP || itype == IT_OPIMM) ? alu : ALU_ADD;
      dec_entry.br  = (itype == IT_BRANCH) ? br : BR_EQ;
      dec_entry.mem = (itype == IT_LOAD || itype == IT_STORE) ? mem : MEM_LW;
      case (imm_sel)
        IMM_I:   dec_entry.imm = imm_i;
        IMM_S:   dec_entry.imm = imm_s;
        IMM_B:   dec_entry.imm = imm_b;
        IMM_U:   dec_entry.imm = imm_u;
        IMM_J:   dec_entry.imm = imm_j;
        default: dec_entry.imm = '0;
      endcase
    end
    if (itype != IT_BRANCH && itype != IT_STORE && itype != IT_UNSUP)
      dec_entry.dst = rd;
    if (itype != IT_LUI && itype != IT_AUIPC && itype != IT_JAL && itype != IT_UNSUP)
      dec_entry.src1 = rs1;
    if (itype == IT_OP || itype == IT_PMUL || itype == IT_BRANCH || itype == IT_STORE)
      dec_entry.src2 = rs2;
  end

  // FIFO state
  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               push, pop;

  // Ready depends only on registered occupancy, never on the consumer
  assign inst_ready_out = (count_q < CNT_W'(DEPTH));
  assign dec_valid_out  = (count_q != '0);
  assign count_out      = count_q;

  assign push = inst_valid_in && inst_ready_out && !flush_in;
  assign pop  = dec_valid_out && dec_ready_in && !flush_in;

  // Next-state for pointers and occupancy; flush wins over push/pop
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_in) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only visible while the queue is non-empty
  always_ff @(posedge clk_in) begin
    if (push) mem_q[wr_ptr_q] <= dec_entry;
  end

  entry_t head;

  // Empty queue presents all-zero data so reset and drained states look alike
  assign head = dec_valid_out ? mem_q[rd_ptr_q] : '0;

  assign itype_out    = head.itype;
  assign alu_func_out = head.alu;
  assign br_func_out  = head.br;
  assign mem_func_out = head.mem;
  assign dst_out      = head.dst;
  assign src1_out     = head.src1;
  assign src2_out     = head.src2;
  assign imm_out      = head.imm;
  assign pc_out       = head.pc;
  assign illegal_out  = dec_valid_out && (head.itype == IT_UNSUP);

endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: directed scenarios with literal expectations,
// then random traffic compared every cycle against a queue-based model.
// Two DUTs share all inputs; they differ only in ENABLE_PMUL.
module tb_decode_queue;

  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        ivld = 1'b0;
  logic [31:0] inst = '0;
  logic [31:0] pc = '0;
  logic        drdy = 1'b0;

  logic [3:0]  itype [2];
  logic [3:0]  alu   [2];
  logic [2:0]  br    [2];
  logic [2:0]  memf  [2];
  logic [4:0]  dst   [2];
  logic [4:0]  src1  [2];
  logic [4:0]  src2  [2];
  logic [31:0] imm   [2];
  logic [31:0] pco   [2];
  logic        ill   [2];
  logic        irdy  [2];
  logic        dvld  [2];
  logic [CW-1:0] cnt [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decode_queue #(.DEPTH(DEPTH), .ENABLE_PMUL(1'b1), .PC_WIDTH(32)) u_p1 (
    .clk_in(clk), .rst_in(rst), .flush_in(flush), .inst_valid_in(ivld),
    .inst_in(inst), .pc_in(pc), .inst_ready_out(irdy[0]), .dec_valid_out(dvld[0]),
    .dec_ready_in(drdy), .itype_out(itype[0]), .alu_func_out(alu[0]),
    .br_func_out(br[0]), .mem_func_out(memf[0]), .dst_out(dst[0]),
    .src1_out(src1[0]), .src2_out(src2[0]), .imm_out(imm[0]), .pc_out(pco[0]),
    .illegal_out(ill[0]), .count_out(cnt[0]));

  decode_queue #(.DEPTH(DEPTH), .ENABLE_PMUL(1'b0), .PC_WIDTH(32)) u_p0 (
    .clk_in(clk), .rst_in(rst), .flush_in(flush), .inst_valid_in(ivld),
    .inst_in(inst), .pc_in(pc), .inst_ready_out(irdy[1]), .dec_valid_out(dvld[1]),
    .dec_ready_in(drdy), .itype_out(itype[1]), .alu_func_out(alu[1]),
    .br_func_out(br[1]), .mem_func_out(memf[1]), .dst_out(dst[1]),
    .src1_out(src1[1]), .src2_out(src2[1]), .imm_out(imm[1]), .pc_out(pco[1]),
    .illegal_out(ill[1]), .count_out(cnt[1]));

  // ---------------- reference model ----------------
  // funct3-indexed lookup tables; -1 marks an illegal encoding
  localparam int ALU_T [8] = '{0, 7, 5, 6, 4, 8, 3, 2};
  localparam int BR_T  [8] = '{0, 1, -1, -1, 2, 4, 3, 5};
  localparam int LD_T  [8] = '{3, 1, 0, -1, 4, 2, -1, -1};
  localparam logic [6:0] OPS [10] = '{7'h33, 7'h13, 7'h63, 7'h37, 7'h6F,
                                      7'h67, 7'h03, 7'h23, 7'h17, 7'h0B};

  typedef struct {
    int          itype, alu, br, mem, dst, src1, src2;
    logic [31:0] imm;
  } exp_t;

  typedef struct {
    logic [31:0] w;
    logic [31:0] pc;
  } ent_t;

  ent_t mq[$];

  function automatic exp_t ref_decode(input logic [31:0] w, input bit pmul);
    exp_t e;
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic signed [31:0] sw;
    int t;
    op = w[6:0]; f3 = w[14:12]; f7 = w[31:25]; sw = $signed(w);
    e.alu = 0; e.br = 0; e.mem = 0; t = 10;
    case (op)
      7'h33: begin
        if (f7 == 7'h00) begin t = 0; e.alu = ALU_T[f3]; end
        else if (f7 == 7'h20 && f3 == 3'd0) begin t = 0; e.alu = 1; end
        else if (f7 == 7'h20 && f3 == 3'd5) begin t = 0; e.alu = 9; end
        else if (f7 == 7'h01 && f3 == 3'd1 && pmul) t = 9;
      end
      7'h13: begin
        if (f3 == 3'd1 && f7 != 7'h00) t = 10;
        else if (f3 == 3'd5 && f7 == 7'h20) begin t = 1; e.alu = 9; end
        else if (f3 == 3'd5 && f7 != 7'h00) t = 10;
        else begin t = 1; e.alu = ALU_T[f3]; end
      end
      7'h63: if (BR_T[f3] >= 0) begin t = 2; e.br = BR_T[f3]; end
      7'h37: t = 3;
      7'h6F: t = 4;
      7'h67: if (f3 == 3'd0) t = 5;
      7'h03: if (LD_T[f3] >= 0) begin t = 6; e.mem = LD_T[f3]; end
      7'h23: if (f3 <= 3'd2) begin t = 7; e.mem = 7 - int'(f3); end
      7'h17: t = 8;
      default: t = 10;
    endcase
    e.itype = t;
    e.dst  = (t inside {2, 7, 10})    ? 0 : int'(w[11:7]);
    e.src1 = (t inside {3, 4, 8, 10}) ? 0 : int'(w[19:15]);
    e.src2 = (t inside {0, 2, 7, 9})  ? int'(w[24:20]) : 0;
    case (t)
      1, 5, 6: e.imm = 32'(sw >>> 20);
      7: e.imm = (32'(sw >>> 20) & 32'hFFFF_FFE0) | 32'(w[11:7]);
      2: e.imm = (32'(sw >>> 19) & 32'hFFFF_F000) | (32'(w[7]) << 11) |
                 (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
      3, 8: e.imm = w & 32'hFFFF_F000;
      4: e.imm = (32'(sw >>> 11) & 32'hFFF0_0000) | (32'(w[19:12]) << 12) |
                 (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
      default: e.imm = '0;
    endcase
    return e;
  endfunction

  // Model queue advances on each edge from the inputs the DUT sees
  always @(posedge clk or posedge rst) begin
    if (rst) mq.delete();
    else if (flush) mq.delete();
    else begin
      bit do_push, do_pop;
      do_push = ivld && (mq.size() < DEPTH);
      do_pop  = (mq.size() > 0) && drdy;
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back('{w: inst, pc: pc});
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare both DUTs against the model mid-cycle
  always @(negedge clk) begin
    int n;
    exp_t e;
    n = mq.size();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("count[%0d]", d), 32'(cnt[d]), 32'(n));
      chk($sformatf("valid[%0d]", d), 32'(dvld[d]), 32'(n > 0));
      chk($sformatf("ready[%0d]", d), 32'(irdy[d]), 32'(n < DEPTH));
      if (n > 0) begin
        e = ref_decode(mq[0].w, d == 0);
        chk($sformatf("pc[%0d]", d), pco[d], mq[0].pc);
      end else begin
        e = '{itype: 0, alu: 0, br: 0, mem: 0, dst: 0, src1: 0, src2: 0, imm: '0};
        chk($sformatf("pc[%0d]", d), pco[d], 32'h0);
      end
      chk($sformatf("itype[%0d]", d), 32'(itype[d]), 32'(e.itype));
      chk($sformatf("alu[%0d]", d), 32'(alu[d]), 32'(e.alu));
      chk($sformatf("br[%0d]", d), 32'(br[d]), 32'(e.br));
      chk($sformatf("mem[%0d]", d), 32'(memf[d]), 32'(e.mem));
      chk($sformatf("dst[%0d]", d), 32'(dst[d]), 32'(e.dst));
      chk($sformatf("src1[%0d]", d), 32'(src1[d]), 32'(e.src1));
      chk($sformatf("src2[%0d]", d), 32'(src2[d]), 32'(e.src2));
      chk($sformatf("imm[%0d]", d), imm[d], e.imm);
      chk($sformatf("illegal[%0d]", d), 32'(ill[d]), 32'(n > 0 && e.itype == 10));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input bit v, input logic [31:0] w, input logic [31:0] p,
                        input bit r, input bit f);
    ivld = v; inst = w; pc = p; drdy = r; flush = f;
  endtask

  function automatic logic [31:0] rand_word();
    logic [6:0] op, f7;
    if ($urandom_range(0, 9) == 0) return $urandom();
    op = OPS[$urandom_range(0, 9)];
    case ($urandom_range(0, 3))
      0: f7 = 7'h00;
      1: f7 = 7'h20;
      2: f7 = 7'h01;
      default: f7 = 7'($urandom());
    endcase
    return {f7, 5'($urandom()), 5'($urandom()), 3'($urandom()), 5'($urandom()), op};
  endfunction

  initial begin
    // Reset state
    step(); step();
    chk("rst_valid", 32'(dvld[0]), 0);
    chk("rst_ready", 32'(irdy[0]), 1);
    chk("rst_count", 32'(cnt[0]), 0);
    chk("rst_imm", imm[0], 0);
    rst = 1'b0;

    // Single addi, one-cycle latency, then drained
    set_in(1, 32'h0050_0093, 32'h100, 1, 0); step();
    chk("addi_valid", 32'(dvld[0]), 1);
    chk("addi_itype", 32'(itype[0]), 1);
    chk("addi_alu", 32'(alu[0]), 0);
    chk("addi_dst", 32'(dst[0]), 1);
    chk("addi_src1", 32'(src1[0]), 0);
    chk("addi_imm", imm[0], 5);
    chk("addi_pc", pco[0], 32'h100);
    set_in(0, 0, 0, 1, 0); step();
    chk("addi_drained", 32'(dvld[0]), 0);

    // Back-pressure: fill, refuse third, drain in order
    set_in(1, 32'h0010_0113, 32'h200, 0, 0); step();
    set_in(1, 32'h0020_0193, 32'h204, 0, 0); step();
    chk("full_ready", 32'(irdy[0]), 0);
    chk("full_count", 32'(cnt[0]), 2);
    set_in(1, 32'h0030_0213, 32'h208, 0, 0); step();
    chk("refused_count", 32'(cnt[0]), 2);
    chk("refused_head", pco[0], 32'h200);
    set_in(0, 0, 0, 1, 0); step();
    chk("drain1_ready", 32'(irdy[0]), 1);
    chk("drain1_pc", pco[0], 32'h204);
    step();
    chk("drain2_count", 32'(cnt[0]), 0);

    // Branch / load decode
    set_in(1, 32'hFE00_0EE3, 32'h300, 1, 0); step();
    chk("beq_itype", 32'(itype[0]), 2);
    chk("beq_br", 32'(br[0]), 0);
    chk("beq_dst", 32'(dst[0]), 0);
    chk("beq_imm", imm[0], 32'hFFFF_FFFC);
    set_in(1, 32'h0000_A003, 32'h304, 1, 0); step();
    chk("lw_itype", 32'(itype[0]), 6);
    chk("lw_mem", 32'(memf[0]), 0);
    set_in(1, 32'h0000_3003, 32'h308, 1, 0); step();
    chk("ld011_itype", 32'(itype[0]), 10);
    chk("ld011_illegal", 32'(ill[0]), 1);

    // PMUL enabled vs disabled
    set_in(1, 32'h0220_91B3, 32'h400, 1, 0); step();
    chk("pmul_itype", 32'(itype[0]), 9);
    chk("pmul_dst", 32'(dst[0]), 3);
    chk("pmul_src1", 32'(src1[0]), 1);
    chk("pmul_src2", 32'(src2[0]), 2);
    chk("nopmul_itype", 32'(itype[1]), 10);
    chk("nopmul_illegal", 32'(ill[1]), 1);

    // Flush with a concurrent push
    set_in(1, 32'h0010_0113, 32'h500, 0, 0); step();
    chk("preflush_count", 32'(cnt[0]), 2);
    set_in(1, 32'h0020_0193, 32'h600, 0, 1); step();
    chk("flush_count", 32'(cnt[0]), 0);
    chk("flush_valid", 32'(dvld[0]), 0);
    chk("flush_ready", 32'(irdy[0]), 1);
    set_in(1, 32'h0030_0213, 32'h700, 0, 0); step();
    chk("postflush_count", 32'(cnt[0]), 1);
    chk("postflush_pc", pco[0], 32'h700);
    chk("postflush_dst", 32'(dst[0]), 4);

    // Asynchronous reset between edges
    set_in(0, 0, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk("async_valid", 32'(dvld[0]), 0);
    chk("async_count", 32'(cnt[0]), 0);
    step();
    rst = 1'b0;

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      set_in($urandom_range(0, 9) < 7, rand_word(), $urandom(),
             $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 3);
      if ($urandom_range(0, 399) == 0) rst = 1'b1;
      step();
      rst = 1'b0;
    end

    set_in(0, 0, 0, 0, 0);
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
